// File: rtl/mem1_lsu.sv
// mem1_lsu: registered MEM1 stage between MEM0 and MEM2.
// Issues load/store requests on a ready/valid data-memory channel, builds
// store byte strobes and lane-replicated write data, and keeps a request on
// the channel until it is accepted, even if the instruction is flushed.
// Optional feature macro: MEM1_ALIGN_CHECK_EN (trap misaligned half/word
// accesses as ale instead of issuing them).

// Checker: a presented request must stay put until it is accepted, and the
// stage never offers a result to MEM2 while a request is outstanding.
module mem1_lsu_chk #(
  parameter int REQ_W = 72
) (
  input logic             clk,
  input logic             rst_n,
  input logic             i_req_valid,
  input logic             i_req_ready,
  input logic [REQ_W-1:0] i_req_fields,
  input logic             i_valid_o
);

  a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (i_req_valid && !i_req_ready) |=> (i_req_valid && $stable(i_req_fields)));

  a_req_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_req_valid && i_valid_o));

endmodule

module mem1_lsu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEST_W = 5,
  parameter int IN_W   = 6 + 2*DATA_W + DEST_W + 1 + ADDR_W,
  parameter int OUT_W  = 1 + 6 + DATA_W + DEST_W + 1 + ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [IN_W-1:0]        mem02mem1_bus_i,
  input  logic                   ctl_mem1_valid_i,
  output logic                   ctl_mem1_allowin_o,
  output logic [OUT_W-1:0]       mem12mem2_bus_o,
  output logic                   ctl_mem1_valid_o,
  input  logic                   ctl_mem2_allowin_i,
  input  logic                   ctl_mem1_flush_i,
  output logic                   dmem_req_valid_o,
  input  logic                   dmem_req_ready_i,
  output logic                   dmem_req_we_o,
  output logic [ADDR_W-1:0]      dmem_req_addr_o,
  output logic [2:0]             dmem_req_size_o,
  output logic [DATA_W/8-1:0]    dmem_req_wstrb_o,
  output logic [DATA_W-1:0]      dmem_req_wdata_o,
  output logic [DEST_W-1:0]      ctl_mem1_dest_o,
  output logic [ADDR_W-1:0]      ctl_mem1_pc_o,
  output logic                   ctl_mem1_ls_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  // Input bus field positions (LSB of each field).
  localparam int WE_BIT   = ADDR_W;
  localparam int DEST_LSB = ADDR_W + 1;
  localparam int ST_LSB   = DEST_LSB + DEST_W;
  localparam int RES_LSB  = ST_LSB + DATA_W;
  localparam int CTL_LSB  = RES_LSB + DATA_W;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_REQ   = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Store byte strobes: size code 4 = byte, 2 = half, 1 = word.
  function automatic logic [STRB_W-1:0] f_strb(input logic [2:0] size,
                                                input logic [OFF_W-1:0] off);
    logic [STRB_W-1:0] base;
    case (size)
      3'd4:    base = STRB_W'(1'b1);
      3'd2:    base = STRB_W'(2'b11);
      3'd1:    base = STRB_W'(4'hF);
      default: base = {STRB_W{1'b0}};
    endcase
    return base << off;
  endfunction

  // Store data replicated across every lane of the access size.
  function automatic logic [DATA_W-1:0] f_wdata(input logic [2:0] size,
                                                 input logic [DATA_W-1:0] st);
    logic [DATA_W-1:0] d;
    case (size)
      3'd4:    d = {STRB_W{st[7:0]}};
      3'd2:    d = {(STRB_W/2){st[15:0]}};
      3'd1:    d = {(DATA_W/32){st[31:0]}};
      default: d = st;
    endcase
    return d;
  endfunction

  // Unpacked input payload.
  logic [5:0]        w_in_ctrl;
  logic [DATA_W-1:0] w_in_result;
  logic [DATA_W-1:0] w_in_st;
  logic [DEST_W-1:0] w_in_wdest;
  logic              w_in_we;
  logic [ADDR_W-1:0] w_in_pc;
  logic              w_in_ls;
  logic              w_in_ale;
  logic              w_capture;
  state_t            w_cap_state;

  assign w_in_ctrl   = mem02mem1_bus_i[CTL_LSB +: 6];
  assign w_in_result = mem02mem1_bus_i[RES_LSB +: DATA_W];
  assign w_in_st     = mem02mem1_bus_i[ST_LSB +: DATA_W];
  assign w_in_wdest  = mem02mem1_bus_i[DEST_LSB +: DEST_W];
  assign w_in_we     = mem02mem1_bus_i[WE_BIT];
  assign w_in_pc     = mem02mem1_bus_i[ADDR_W-1:0];
  assign w_in_ls     = w_in_ctrl[5] | w_in_ctrl[4];

`ifdef MEM1_ALIGN_CHECK_EN
  // A word only needs 4-byte alignment, so on 64-bit data the upper word
  // lane (addr[2] = 1) is a legal target.
  assign w_in_ale = w_in_ls &&
                    (((w_in_ctrl[2:0] == 3'd2) && w_in_result[0]) ||
                     ((w_in_ctrl[2:0] == 3'd1) && (w_in_result[1:0] != 2'b00)));
`else
  assign w_in_ale = 1'b0;
`endif

  // Held state and payload.
  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_killed;
  logic              w_killed_nxt;
  logic [5:0]        r_ctrl;
  logic [DATA_W-1:0] r_result;
  logic [DEST_W-1:0] r_wdest;
  logic              r_we;
  logic [ADDR_W-1:0] r_pc;
  logic              r_ale;
  logic [STRB_W-1:0] r_wstrb;
  logic [DATA_W-1:0] r_wdata;
  logic              w_in_req;
  logic              w_we_out;

  assign ctl_mem1_allowin_o = (r_state == S_EMPTY) ||
                              ((r_state == S_DONE) && ctl_mem2_allowin_i);
  assign w_capture   = ctl_mem1_valid_i && ctl_mem1_allowin_o && !ctl_mem1_flush_i;
  assign w_cap_state = (w_in_ls && !w_in_ale) ? S_REQ : S_DONE;

  // Next-state and killed-flag decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_killed_nxt = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_capture) begin
          w_state_nxt = w_cap_state;
        end else begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_REQ: begin
        if (dmem_req_ready_i) begin
          // A flushed request still completes, but its result is dropped.
          if (r_killed || ctl_mem1_flush_i) begin
            w_state_nxt = S_EMPTY;
          end else begin
            w_state_nxt = S_DONE;
          end
          w_killed_nxt = 1'b0;
        end else begin
          w_state_nxt  = S_REQ;
          w_killed_nxt = r_killed || ctl_mem1_flush_i;
        end
      end
      S_DONE: begin
        if (ctl_mem1_flush_i) begin
          w_state_nxt = S_EMPTY;
        end else if (ctl_mem2_allowin_i) begin
          if (w_capture) begin
            w_state_nxt = w_cap_state;
          end else begin
            w_state_nxt = S_EMPTY;
          end
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt  = S_EMPTY;
        w_killed_nxt = 1'b0;
      end
    endcase
  end

  // State and killed-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_EMPTY;
      r_killed <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_killed <= w_killed_nxt;
    end
  end

  // Payload capture; request strobes/data are precomputed so the channel
  // outputs come straight from flops while the request is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl   <= 6'd0;
      r_result <= {DATA_W{1'b0}};
      r_wdest  <= {DEST_W{1'b0}};
      r_we     <= 1'b0;
      r_pc     <= {ADDR_W{1'b0}};
      r_ale    <= 1'b0;
      r_wstrb  <= {STRB_W{1'b0}};
      r_wdata  <= {DATA_W{1'b0}};
    end else if (w_capture) begin
      r_ctrl   <= w_in_ctrl;
      r_result <= w_in_result;
      r_wdest  <= w_in_wdest;
      r_we     <= w_in_we;
      r_pc     <= w_in_pc;
      r_ale    <= w_in_ale;
      r_wstrb  <= w_in_ctrl[4] ? f_strb(w_in_ctrl[2:0], w_in_result[OFF_W-1:0])
                               : {STRB_W{1'b0}};
      r_wdata  <= w_in_ctrl[4] ? f_wdata(w_in_ctrl[2:0], w_in_st)
                               : {DATA_W{1'b0}};
    end else begin
      r_ctrl   <= r_ctrl;
      r_result <= r_result;
      r_wdest  <= r_wdest;
      r_we     <= r_we;
      r_pc     <= r_pc;
      r_ale    <= r_ale;
      r_wstrb  <= r_wstrb;
      r_wdata  <= r_wdata;
    end
  end

  assign w_in_req = (r_state == S_REQ);
  assign w_we_out = r_we & ~r_ale;

  // Memory channel: only driven while a request is presented.
  assign dmem_req_valid_o = w_in_req;
  assign dmem_req_we_o    = w_in_req & r_ctrl[4];
  assign dmem_req_addr_o  = w_in_req ? ADDR_W'(r_result) : {ADDR_W{1'b0}};
  assign dmem_req_size_o  = w_in_req ? r_ctrl[2:0] : 3'd0;
  assign dmem_req_wstrb_o = w_in_req ? r_wstrb : {STRB_W{1'b0}};
  assign dmem_req_wdata_o = w_in_req ? r_wdata : {DATA_W{1'b0}};

  // MEM2 side and hazard/control outputs.
  assign ctl_mem1_valid_o = (r_state == S_DONE);
  assign mem12mem2_bus_o  = {r_ale, r_ctrl, r_result, r_wdest, w_we_out, r_pc};
  assign ctl_mem1_dest_o  = ((r_state != S_EMPTY) && !r_killed && w_we_out)
                            ? r_wdest : {DEST_W{1'b0}};
  assign ctl_mem1_ls_o    = (r_state != S_EMPTY) && (r_ctrl[5] | r_ctrl[4]);
  assign ctl_mem1_pc_o    = r_pc;

  mem1_lsu_chk #(
    .REQ_W(1 + ADDR_W + 3 + STRB_W + DATA_W)
  ) u_chk (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (dmem_req_valid_o),
    .i_req_ready  (dmem_req_ready_i),
    .i_req_fields ({dmem_req_we_o, dmem_req_addr_o, dmem_req_size_o,
                    dmem_req_wstrb_o, dmem_req_wdata_o}),
    .i_valid_o    (ctl_mem1_valid_o)
  );

endmodule

// File: tb/tb_mem1_lsu.sv
// Self-checking bench for mem1_lsu (DATA_W = 32): directed scenarios followed
// by randomized traffic scored against a transaction-level reference model.
module tb_mem1_lsu;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEST_W = 5;
  localparam int IN_W   = 6 + 2*DATA_W + DEST_W + 1 + ADDR_W;
  localparam int OUT_W  = 1 + 6 + DATA_W + DEST_W + 1 + ADDR_W;
  localparam int REQ_W  = 1 + ADDR_W + 3 + 4 + DATA_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [IN_W-1:0]   bus_i;
  logic              valid_i;
  logic              allowin_o;
  logic [OUT_W-1:0]  bus_o;
  logic              valid_o;
  logic              mem2_allowin;
  logic              flush;
  logic              req_valid;
  logic              ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_size;
  logic [3:0]        wstrb;
  logic [DATA_W-1:0] wdata;
  logic [DEST_W-1:0] dest;
  logic [ADDR_W-1:0] pc_o;
  logic              ls;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem1_lsu dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .mem02mem1_bus_i   (bus_i),
    .ctl_mem1_valid_i  (valid_i),
    .ctl_mem1_allowin_o(allowin_o),
    .mem12mem2_bus_o   (bus_o),
    .ctl_mem1_valid_o  (valid_o),
    .ctl_mem2_allowin_i(mem2_allowin),
    .ctl_mem1_flush_i  (flush),
    .dmem_req_valid_o  (req_valid),
    .dmem_req_ready_i  (ready),
    .dmem_req_we_o     (req_we),
    .dmem_req_addr_o   (req_addr),
    .dmem_req_size_o   (req_size),
    .dmem_req_wstrb_o  (wstrb),
    .dmem_req_wdata_o  (wdata),
    .ctl_mem1_dest_o   (dest),
    .ctl_mem1_pc_o     (pc_o),
    .ctl_mem1_ls_o     (ls)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [IN_W-1:0] mk_in(input logic [5:0] ctrl, input logic [31:0] res,
      input logic [31:0] st, input logic [4:0] wd, input logic we, input logic [31:0] pc);
    return {ctrl, res, st, wd, we, pc};
  endfunction

  function automatic logic exp_ale(input logic [5:0] ctrl, input logic [31:0] addr);
`ifdef MEM1_ALIGN_CHECK_EN
    int sz;
    sz = int'(ctrl[2:0]);
    if (!(ctrl[5] || ctrl[4])) return 1'b0;
    if (sz == 2 && (addr % 2) != 0) return 1'b1;
    if (sz == 1 && (addr % 4) != 0) return 1'b1;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [OUT_W-1:0] exp_bus(input logic [5:0] ctrl, input logic [31:0] res,
      input logic [4:0] wd, input logic we, input logic [31:0] pc);
    logic a;
    a = exp_ale(ctrl, res);
    return {a, ctrl, res, wd, we & ~a, pc};
  endfunction

  function automatic logic [3:0] exp_strb(input logic [5:0] ctrl, input logic [31:0] addr);
    int off;
    int s;
    off = int'(addr % 4);
    case (int'(ctrl[2:0]))
      4:       s = 1 << off;
      2:       s = 3 << off;
      1:       s = 15 << off;
      default: s = 0;
    endcase
    s = s & 15;
    return ctrl[4] ? s[3:0] : 4'h0;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [5:0] ctrl, input logic [31:0] st);
    logic [31:0] b;
    logic [31:0] h;
    b = {24'h0, st[7:0]};
    h = {16'h0, st[15:0]};
    case (int'(ctrl[2:0]))
      4:       return b * 32'h0101_0101;
      2:       return h * 32'h0001_0001;
      default: return st;
    endcase
  endfunction

  // Request fields as compared: write data only matters for stores.
  function automatic logic [REQ_W-1:0] exp_req(input logic [5:0] ctrl, input logic [31:0] addr,
      input logic [31:0] st);
    return {ctrl[4], addr, ctrl[2:0], exp_strb(ctrl, addr),
            ctrl[4] ? exp_wdata(ctrl, st) : 32'h0};
  endfunction

  logic [OUT_W-1:0] exp_q[$];
  logic [REQ_W-1:0] req_q[$];

  logic [5:0]  c_ctrl;
  logic [31:0] c_res;
  logic [31:0] c_st;
  logic [4:0]  c_wd;
  logic        c_we;
  logic [31:0] c_pc;

  initial begin
    rst_n = 1'b0; bus_i = '0; valid_i = 1'b0; mem2_allowin = 1'b1;
    flush = 1'b0; ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_valid_o", valid_o, 1'b0);
    chk("rst_allowin", allowin_o, 1'b1);
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_bus", bus_o, '0);
    chk("rst_req_fields", {req_we, req_addr, req_size, wstrb, wdata}, '0);
    chk("rst_ctl", {dest, pc_o, ls}, '0);
    rst_n = 1'b1;
    tick();

    // ALU op passes through in one cycle
    bus_i = mk_in(6'h00, 32'h1234_5678, 32'h0, 5'd7, 1'b1, 32'h1C00_0000);
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    chk("alu_valid_o", valid_o, 1'b1);
    chk("alu_bus", bus_o, exp_bus(6'h00, 32'h1234_5678, 5'd7, 1'b1, 32'h1C00_0000));
    chk("alu_dest", dest, 5'd7);
    chk("alu_no_req", req_valid, 1'b0);
    tick();
    chk("alu_drain", valid_o, 1'b0);

    // Store byte at 0x1003
    bus_i = mk_in(6'b010100, 32'h1003, 32'hAABB_CCDD, 5'd0, 1'b0, 32'h1C00_0004);
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    chk("sb_req_valid", req_valid, 1'b1);
    chk("sb_req_we", req_we, 1'b1);
    chk("sb_wstrb", wstrb, 4'b1000);
    chk("sb_wdata", wdata, 32'hDDDD_DDDD);
    chk("sb_addr", req_addr, 32'h1003);
    chk("sb_allowin", allowin_o, 1'b0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("sb_valid_o", valid_o, 1'b1);
    chk("sb_req_drop", req_valid, 1'b0);
    chk("sb_ls", ls, 1'b1);
    tick();
    chk("sb_drain", valid_o, 1'b0);

    // Load half at 0x2002, ready low for 3 cycles
    bus_i = mk_in(6'b101010, 32'h2002, 32'h5555_AAAA, 5'd3, 1'b1, 32'h1C00_0010);
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("lh_stall_req", {req_valid, req_we, req_addr, req_size, wstrb},
          {1'b1, 1'b0, 32'h2002, 3'd2, 4'h0});
      chk("lh_stall_allowin", allowin_o, 1'b0);
      chk("lh_stall_valid_o", valid_o, 1'b0);
      tick();
    end
    ready = 1'b1;
    chk("lh_req_at_ready", req_valid, 1'b1);
    tick();
    ready = 1'b0;
    chk("lh_valid_o", valid_o, 1'b1);
    chk("lh_bus", bus_o, exp_bus(6'b101010, 32'h2002, 5'd3, 1'b1, 32'h1C00_0010));
    tick();

    // Flush during a stalled load to 0x40
    bus_i = mk_in(6'b100001, 32'h40, 32'h0, 5'd9, 1'b1, 32'h1C00_0020);
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    chk("fl_req_valid", req_valid, 1'b1);
    chk("fl_dest_before", dest, 5'd9);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_req_held", {req_valid, req_addr}, {1'b1, 32'h40});
    chk("fl_dest_zero", dest, 5'd0);
    chk("fl_no_valid_o", valid_o, 1'b0);
    tick();
    chk("fl_req_held2", req_valid, 1'b1);
    chk("fl_dest_zero2", dest, 5'd0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("fl_empty", {req_valid, valid_o, allowin_o, ls}, 4'b0010);
    tick();
    chk("fl_no_valid_o2", valid_o, 1'b0);

    // Misaligned load word at 0x1002
    bus_i = mk_in(6'b100001, 32'h1002, 32'h0, 5'd4, 1'b1, 32'h1C00_0030);
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
`ifdef MEM1_ALIGN_CHECK_EN
    chk("mis_no_req", req_valid, 1'b0);
    chk("mis_valid_o", valid_o, 1'b1);
    chk("mis_ale", bus_o[OUT_W-1], 1'b1);
    chk("mis_bus", bus_o, exp_bus(6'b100001, 32'h1002, 5'd4, 1'b1, 32'h1C00_0030));
    chk("mis_dest", dest, 5'd0);
`else
    chk("mis_req", {req_valid, req_addr}, {1'b1, 32'h1002});
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("mis_valid_o", valid_o, 1'b1);
    chk("mis_bus", bus_o, exp_bus(6'b100001, 32'h1002, 5'd4, 1'b1, 32'h1C00_0030));
`endif
    tick();

    // MEM2 back-pressure, then handoff and capture in the same cycle
    mem2_allowin = 1'b0;
    bus_i = mk_in(6'h00, 32'hA0A0_0001, 32'h0, 5'd11, 1'b1, 32'h1C00_0040);
    valid_i = 1'b1;
    tick();
    bus_i = mk_in(6'h00, 32'hB0B0_0002, 32'h0, 5'd12, 1'b0, 32'h1C00_0044);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("bp_allowin", allowin_o, 1'b0);
      chk("bp_hold_bus", bus_o, exp_bus(6'h00, 32'hA0A0_0001, 5'd11, 1'b1, 32'h1C00_0040));
      chk("bp_valid_o", valid_o, 1'b1);
      tick();
    end
    mem2_allowin = 1'b1;
    #1;
    chk("bp_release_allowin", allowin_o, 1'b1);
    tick();
    valid_i = 1'b0;
    chk("bp_new_bus", bus_o, exp_bus(6'h00, 32'hB0B0_0002, 5'd12, 1'b0, 32'h1C00_0044));
    chk("bp_new_valid", valid_o, 1'b1);
    tick();
    chk("bp_drain", valid_o, 1'b0);

    // Randomized traffic against the scoreboard; the tail drains the stage.
    for (int cyc = 0; cyc < 3030; cyc++) begin
      logic cap;
      cap = 1'b0;
      if (cyc < 3000 && !valid_i && $urandom_range(0, 3) != 0) begin
        int kind;
        int sel;
        kind = int'($urandom_range(0, 2));
        sel  = int'($urandom_range(0, 2));
        c_res = $urandom;
        if ($urandom_range(0, 1) == 1)
          c_res = c_res & ((sel == 0) ? 32'hFFFF_FFFF : (sel == 1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC);
        c_ctrl = {kind == 1, kind == 2, 1'($urandom_range(0, 1)),
                  (sel == 0) ? 3'd4 : (sel == 1) ? 3'd2 : 3'd1};
        c_st  = $urandom;
        c_wd  = 5'($urandom);
        c_we  = 1'($urandom_range(0, 1));
        c_pc  = $urandom;
        bus_i = mk_in(c_ctrl, c_res, c_st, c_wd, c_we, c_pc);
        valid_i = 1'b1;
      end
      if (cyc >= 3000) begin
        ready = 1'b1;
        mem2_allowin = 1'b1;
      end else begin
        ready = ($urandom_range(0, 2) != 0);
        mem2_allowin = ($urandom_range(0, 3) != 0);
      end
      #1;
      if (req_valid && ready) begin
        chk("rnd_req_expected", req_q.size() != 0, 1'b1);
        if (req_q.size() != 0)
          chk("rnd_req", {req_we, req_addr, req_size, wstrb, req_we ? wdata : 32'h0},
              req_q.pop_front());
      end
      if (valid_o && mem2_allowin) begin
        chk("rnd_bus_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0)
          chk("rnd_bus", bus_o, exp_q.pop_front());
      end
      if (valid_i && allowin_o) begin
        exp_q.push_back(exp_bus(c_ctrl, c_res, c_wd, c_we, c_pc));
        if ((c_ctrl[5] || c_ctrl[4]) && !exp_ale(c_ctrl, c_res))
          req_q.push_back(exp_req(c_ctrl, c_res, c_st));
        cap = 1'b1;
      end
      tick();
      if (cap) valid_i = 1'b0;
    end
    chk("rnd_all_retired", exp_q.size(), 0);
    chk("rnd_all_requested", req_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
